wide_shift_sequencer: RTL and testbench

- Multi-cycle controller that performs 16-bit logical shifts of a register pair {opHi, opLo} using the datapath's single 8-bit Shifter.
- Sits directly upstream and downstream of the Shifter: it drives the Shifter's operand, shiftAmount and direction inputs, and registers the Shifter's result.
- Fixed 3-cycle operation schedule, start/busy/done handshake; used for the ISA's double-word shift instructions.

---
 rtl/wide_shift_sequencer.sv | 135 +++++++++++++
 tb/tb_wide_shift_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/wide_shift_sequencer.sv
// Sequences a 16-bit logical shift of {opHi, opLo} over three passes through
// the shared 8-bit Shifter, registering partial products between passes.
//
// state | meaning
// IDLE  | waiting for start, Shifter drive parked at zero
// OP0   | shift the byte that keeps its position (lo for left, hi for right)
// OP1   | shift the same byte the other way to form the cross-byte carry
// OP2   | shift the other byte, merge with carry, update results
// DONE  | one-cycle done; start here launches back-to-back
module wide_shift_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dirIn,
    input  logic [7:0]       amount,
    input  logic [WIDTH-1:0] opHi,
    input  logic [WIDTH-1:0] opLo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultHi,
    output logic [WIDTH-1:0] resultLo,
    output logic [WIDTH-1:0] shOperand,
    output logic [7:0]       shAmount,
    output logic             shDirection,
    input  logic [WIDTH-1:0] shResult
);

    typedef enum logic [2:0] {IDLE, OP0, OP1, OP2, DONE} state_t;

    localparam logic [7:0] HALF = 8'(WIDTH);

    state_t           state, state_nxt;
    logic             accept;
    logic             dir_r;
    logic [7:0]       amt_r;
    logic [WIDTH-1:0] hi_r, lo_r, part_r, carry_r;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        busy        = 1'b0;
        shOperand   = '0;
        shAmount    = '0;
        shDirection = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = OP0;
                end
            end
            OP0: begin
                busy        = 1'b1;
                state_nxt   = OP1;
                shOperand   = dir_r ? hi_r : lo_r;
                shAmount    = amt_r;
                shDirection = dir_r;
            end
            OP1: begin
                busy      = 1'b1;
                state_nxt = OP2;
                shOperand = dir_r ? hi_r : lo_r;
                // Bits crossing the byte boundary: opposite shift by the complement
                // for small counts, same-direction shift by the excess otherwise.
                if (amt_r < HALF) begin
                    shAmount    = HALF - amt_r;
                    shDirection = ~dir_r;
                end else begin
                    shAmount    = amt_r - HALF;
                    shDirection = dir_r;
                end
            end
            OP2: begin
                busy        = 1'b1;
                state_nxt   = DONE;
                shOperand   = dir_r ? lo_r : hi_r;
                shAmount    = amt_r;
                shDirection = dir_r;
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = OP0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_r    <= 1'b0;
            amt_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            part_r   <= '0;
            carry_r  <= '0;
            resultHi <= '0;
            resultLo <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == OP2);
            if (accept) begin
                dir_r <= dirIn;
                amt_r <= amount;
                hi_r  <= opHi;
                lo_r  <= opLo;
            end
            case (state)
                OP0: part_r  <= shResult;
                OP1: carry_r <= shResult;
                OP2: begin
                    if (dir_r) begin
                        resultHi <= part_r;
                        resultLo <= shResult | carry_r;
                    end else begin
                        resultHi <= shResult | carry_r;
                        resultLo <= part_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_shift_sequencer.sv
// Directed bench for wide_shift_sequencer with a behavioural 8-bit Shifter.
module tb_wide_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       dirIn;
    logic [7:0] amount;
    logic [7:0] opHi;
    logic [7:0] opLo;
    logic       busy;
    logic       done;
    logic [7:0] resultHi;
    logic [7:0] resultLo;
    logic [7:0] shOperand;
    logic [7:0] shAmount;
    logic       shDirection;
    logic [7:0] shResult;

    int n_checks = 0;
    int n_pass   = 0;

    wide_shift_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .dirIn(dirIn), .amount(amount),
        .opHi(opHi), .opLo(opLo), .busy(busy), .done(done),
        .resultHi(resultHi), .resultLo(resultLo),
        .shOperand(shOperand), .shAmount(shAmount), .shDirection(shDirection),
        .shResult(shResult)
    );

    always #5 clk = ~clk;

    // Shifter: logical shift, zero for any amount of 8 or more
    always_comb begin
        shResult = 8'h00;
        if (shAmount < 8'd8)
            shResult = shDirection ? (shOperand >> shAmount) : (shOperand << shAmount);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Returns in the OP0 cycle (one negedge after start was sampled)
    task automatic launch(input logic d, input logic [7:0] n, input logic [7:0] h, input logic [7:0] l);
        @(negedge clk);
        start = 1'b1; dirIn = d; amount = n; opHi = h; opLo = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns in the DONE cycle
    task automatic run_op(input string tag, input logic d, input logic [7:0] n,
                          input logic [15:0] opnd, input logic [15:0] exp);
        launch(d, n, opnd[15:8], opnd[7:0]);
        check({tag, " op0 busy/done"}, {14'd0, busy, done}, 16'b10);
        @(negedge clk);
        check({tag, " op1 busy/done"}, {14'd0, busy, done}, 16'b10);
        @(negedge clk);
        check({tag, " op2 busy/done"}, {14'd0, busy, done}, 16'b10);
        @(negedge clk);
        check({tag, " done busy/done"}, {14'd0, busy, done}, 16'b01);
        check({tag, " result"}, {resultHi, resultLo}, exp);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dirIn = 1'b0; amount = 8'd0; opHi = 8'd0; opLo = 8'd0;
        repeat (3) @(negedge clk);
        check("reset busy/done", {14'd0, busy, done}, 16'b00);
        check("reset result", {resultHi, resultLo}, 16'h0000);
        check("reset drive", {shDirection, shAmount, shOperand[6:0]}, 16'h0000);
        check("reset drive op msb", {15'd0, shOperand[7]}, 16'h0000);
        reset = 1'b0;

        // Test 1: left by 4 with an OP1 drive check
        launch(1'b0, 8'd4, 8'h81, 8'h23);
        check("t1 op0 busy", {15'd0, busy}, 16'd1);
        @(negedge clk);
        check("t1 op1 busy", {15'd0, busy}, 16'd1);
        check("t1 op1 drive", {7'd0, shDirection, shOperand}, 16'h0123);
        check("t1 op1 amount", {8'd0, shAmount}, 16'h0004);
        @(negedge clk);
        check("t1 op2 busy/done", {14'd0, busy, done}, 16'b10);
        @(negedge clk);
        check("t1 done busy/done", {14'd0, busy, done}, 16'b01);
        check("t1 result", {resultHi, resultLo}, 16'h1230);
        check("t1 done drive", {7'd0, shDirection, shOperand}, 16'h0000);
        @(negedge clk);
        check("t1 idle busy/done", {14'd0, busy, done}, 16'b00);
        check("t1 result hold", {resultHi, resultLo}, 16'h1230);

        // Right shifts, left shifts, boundaries
        run_op("r4",    1'b1, 8'd4,   16'h8123, 16'h0812);
        run_op("r9",    1'b1, 8'd9,   16'hABCD, 16'h0055);
        run_op("l8",    1'b0, 8'd8,   16'hABCD, 16'hCD00);
        run_op("l12",   1'b0, 8'd12,  16'hABCD, 16'hD000);
        run_op("l7",    1'b0, 8'd7,   16'hABCD, 16'hE680);
        run_op("l0",    1'b0, 8'd0,   16'hABCD, 16'hABCD);
        run_op("r0",    1'b1, 8'd0,   16'hABCD, 16'hABCD);
        run_op("l16",   1'b0, 8'd16,  16'hABCD, 16'h0000);
        run_op("r16",   1'b1, 8'd16,  16'hABCD, 16'h0000);
        run_op("l255",  1'b0, 8'd255, 16'hABCD, 16'h0000);
        run_op("r255",  1'b1, 8'd255, 16'hABCD, 16'h0000);
        run_op("r8",    1'b1, 8'd8,   16'hABCD, 16'h00AB);

        // start pulsed during OP1 is ignored
        launch(1'b0, 8'd4, 8'h81, 8'h23);
        @(negedge clk);
        start = 1'b1; dirIn = 1'b1; amount = 8'd1; opHi = 8'hFF; opLo = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ign done", {14'd0, busy, done}, 16'b01);
        check("ign result", {resultHi, resultLo}, 16'h1230);
        @(negedge clk);
        check("ign no relaunch", {14'd0, busy, done}, 16'b00);

        // start held in DONE launches back-to-back
        run_op("b2b a", 1'b0, 8'd8, 16'hABCD, 16'hCD00);
        start = 1'b1; dirIn = 1'b1; amount = 8'd4; opHi = 8'h81; opLo = 8'h23;
        @(negedge clk);
        start = 1'b0;
        check("b2b op0 busy/done", {14'd0, busy, done}, 16'b10);
        @(negedge clk);
        check("b2b result hold", {resultHi, resultLo}, 16'hCD00);
        @(negedge clk);
        check("b2b op2 busy/done", {14'd0, busy, done}, 16'b10);
        @(negedge clk);
        check("b2b b done", {14'd0, busy, done}, 16'b01);
        check("b2b b result", {resultHi, resultLo}, 16'h0812);

        // reset during OP1 aborts the operation
        launch(1'b0, 8'd12, 8'hAB, 8'hCD);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst busy/done", {14'd0, busy, done}, 16'b00);
        check("rst result", {resultHi, resultLo}, 16'h0000);
        check("rst drive", {7'd0, shDirection, shOperand}, 16'h0000);
        @(negedge clk);
        check("rst no done 1", {14'd0, busy, done}, 16'b00);
        @(negedge clk);
        check("rst no done 2", {14'd0, busy, done}, 16'b00);
        check("rst result hold", {resultHi, resultLo}, 16'h0000);
        run_op("post rst", 1'b0, 8'd7, 16'hABCD, 16'hE680);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
